hps_spi_bridge: RTL and testbench
=================================

// Module: hps_spi_bridge
// PURPOSE
//  Next-generation HPS<->FPGA link: SPI slave with built-in oversampled shift engine, configurable word width and SPI mode.
//  TX and RX words are buffered in FIFOs. Per-word strobe, sticky error flags and a status word are provided for the sys core.
//  Sits between the HPS SPI pins and the command decoder / OSD / IO logic in the sys_clk domain.
// PARAMETERS
//  WORD_W         16     bits per SPI word (4..32)
//  DEPTH          8      TX and RX FIFO depth in words (power of 2, >=2)
//  CPOL           0      idle level of spi_clk
//  CPHA           1      0: sample on leading edge; 1: drive on leading edge, sample on trailing edge
//  UNDERRUN_WORD  0      word shifted out when the TX FIFO is empty at word load
// PORTS
//  sys_clk      in   1              system clock; everything is synchronous to it
//  reset_n      in   1              synchronous reset, active low
//  spi_clk      in   1              HPS SPI clock, asynchronous; sys_clk >= 8x spi_clk
//  spi_cs       in   1              chip select, active low, asynchronous
//  spi_mosi     in   1              serial data from HPS, MSB first
//  spi_miso     out  1              serial data to HPS, MSB first
//  tx_data      in   WORD_W         word to send to HPS
//  tx_valid     in   1              push tx_data when tx_valid & tx_ready
//  tx_ready     out  1              TX FIFO not full
//  rx_data      out  WORD_W         oldest received word
//  rx_valid     out  1              RX FIFO not empty
//  rx_ready     in   1              pop when rx_valid & rx_ready
//  io_strobe    out  1              1-cycle pulse per completed received word
//  clr_flags    in   1              clears sticky flags
//  fpga_enable  in   1              passed into status
//  osd_enable   in   1              passed into status
//  io_enable    in   1              passed into status
//  status       out  32             {11'b0, io_en[20], osd_en[19], fpga_en[18], 14'b0, frame_err[3], tx_underrun[2], rx_overflow[1], cs_active[0]}
// BEHAVIOUR
//  Reset (reset_n low at a sys_clk edge):
//   - FIFOs emptied; shift/bit counters cleared; flags cleared.
//   - spi_miso=0, io_strobe=0, rx_valid=0, tx_ready=1, cs_active=0.
//  Input sync: spi_clk, spi_cs, spi_mosi each pass 2 FFs, then an edge register.
//   - Sample/drive edges are derived from the CPOL/CPHA rules.
//   - Pin-to-internal-event latency is 3 sys_clk.
//  FSM IDLE -> ACTIVE on synced cs falling:
//   - Bit counter := 0; load tx shift reg (pop TX FIFO, else UNDERRUN_WORD and set tx_underrun).
//   - spi_miso := MSB in the same cycle as the load.
//  ACTIVE, sample edge:
//   - rx shift reg := {rx[WORD_W-2:0], mosi}; count++.
//   - At count==WORD_W: push word to RX FIFO, pulse io_strobe, count := 0, reload tx shift reg as on entry.
//   - RX FIFO full: word dropped, rx_overflow set, io_strobe still pulses.
//  ACTIVE, drive edge:
//   - tx shift left by 1; spi_miso := new MSB.
//   - CPHA=1: the first drive edge of each word does not shift (MSB already presented).
//   - Drive and reload in the same cycle: reload wins.
//  ACTIVE -> IDLE on synced cs rising:
//   - count != 0: partial word discarded, frame_err set, no strobe.
//   - spi_miso := 0. The already-loaded TX word is lost (not returned to the FIFO).
//  cs rising in the same cycle as word completion: complete word is pushed first, then IDLE; frame_err stays clear.
//  FIFOs:
//   - Simultaneous push and pop on a full or empty FIFO is legal.
//   - Full + pop + push keeps level; empty + push + pop does not pass through (rx_valid rises next cycle).
//   - Pointers wrap modulo DEPTH, with an extra bit for full/empty.
//  Sticky flags:
//   - clr_flags clears them.
//   - A set event in the same cycle as clr_flags wins (flag stays 1).
//  cs_active = FSM in ACTIVE. Status register updates 1 cycle after the event.
// STRUCTURE
//  hps_spi_defs.vh: status bit indices and FSM state encodings.
//  Sub-module hps_sync_fifo (WIDTH, DEPTH), instantiated twice for TX and RX; first-word-fall-through read.
//  Top: synchronisers, edge detect, FSM, shift regs, flags.
// TESTING
//  1. WORD_W=16, CPHA=1: push 16'hA55A to TX, HPS sends 16'h1234 -> rx_data=16'h1234, one io_strobe, HPS reads 16'hA55A.
//  2. TX empty, HPS sends 3 words -> MISO returns UNDERRUN_WORD x3, tx_underrun=1; clr_flags -> 0.
//  3. DEPTH=8, rx_ready=0, HPS sends 9 words -> 8 in FIFO (first 8 values in order), rx_overflow=1, 9 io_strobe pulses.
//  4. cs deasserted after 7 bits -> no strobe, RX level unchanged, frame_err=1; next frame receives 16'hBEEF correctly.
//  5. reset_n low mid-word, then HPS sends 16'h0F0F -> outputs at reset values; next full word received exactly once.
//  6. Regress CPOL/CPHA all 4 combos and WORD_W=8/32 with random data and back-to-back words -> bit-exact loopback.

Source files
------------

// File: rtl/hps_spi_bridge_pkg.sv
// Shared definitions for the HPS SPI bridge: FSM states, status bit positions
// and the status word packer.
package hps_spi_bridge_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  localparam int STAT_CS_ACTIVE   = 0;
  localparam int STAT_RX_OVERFLOW = 1;
  localparam int STAT_TX_UNDERRUN = 2;
  localparam int STAT_FRAME_ERR   = 3;
  localparam int STAT_FPGA_EN     = 18;
  localparam int STAT_OSD_EN      = 19;
  localparam int STAT_IO_EN       = 20;

  function automatic logic [31:0] pack_status(
    input logic io_en,
    input logic osd_en,
    input logic fpga_en,
    input logic frame_err,
    input logic tx_underrun,
    input logic rx_overflow,
    input logic cs_active
  );
    logic [31:0] s;
    s                   = '0;
    s[STAT_IO_EN]       = io_en;
    s[STAT_OSD_EN]      = osd_en;
    s[STAT_FPGA_EN]     = fpga_en;
    s[STAT_FRAME_ERR]   = frame_err;
    s[STAT_TX_UNDERRUN] = tx_underrun;
    s[STAT_RX_OVERFLOW] = rx_overflow;
    s[STAT_CS_ACTIVE]   = cs_active;
    return s;
  endfunction

endpackage

// File: rtl/hps_spi_bridge_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry an extra wrap bit
// so full and empty are distinguishable.
module hps_spi_bridge_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // A pop on a full FIFO frees the slot the simultaneous push writes into.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/hps_spi_bridge.sv
// SPI slave bridge between the HPS pins and the sys_clk domain: oversampled
// pin synchronisers, word shift engine, TX/RX FIFOs and sticky status flags.
module hps_spi_bridge
  import hps_spi_bridge_pkg::*;
#(
  parameter int               WORD_W        = 16,
  parameter int               DEPTH         = 8,
  parameter bit               CPOL          = 1'b0,
  parameter bit               CPHA          = 1'b1,
  parameter logic [WORD_W-1:0] UNDERRUN_WORD = '0
) (
  input  logic              i_sys_clk,
  input  logic              i_reset_n,
  input  logic              i_spi_clk,
  input  logic              i_spi_cs,
  input  logic              i_spi_mosi,
  output logic              o_spi_miso,
  input  logic [WORD_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic [WORD_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  input  logic              i_rx_ready,
  output logic              o_io_strobe,
  input  logic              i_clr_flags,
  input  logic              i_fpga_enable,
  input  logic              i_osd_enable,
  input  logic              i_io_enable,
  output logic [31:0]       o_status
);

  localparam int               CNT_W    = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;

  logic r_clk_s1, r_clk_s2, r_clk_d;
  logic r_cs_s1, r_cs_s2, r_cs_d;
  logic r_mosi_s1, r_mosi_s2;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic [WORD_W-1:0] r_rx_sh, w_rx_sh_nxt;
  logic [WORD_W-1:0] r_tx_sh, w_tx_sh_nxt;
  logic              r_miso, w_miso_nxt;
  logic              r_strobe;
  logic [31:0]       r_status;

  logic w_load, w_rx_push, w_frame_set, w_underrun_set, w_overflow_set;
  logic w_tx_pop, w_tx_push, w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic [WORD_W-1:0] w_tx_head;
  logic w_clk_rise, w_clk_fall, w_lead, w_trail, w_sample, w_drive;
  logic w_cs_fall, w_cs_rise;

  always_ff @(posedge i_sys_clk) begin
    if (!i_reset_n) begin
      {r_clk_s1, r_clk_s2, r_clk_d} <= {3{CPOL}};
      {r_cs_s1, r_cs_s2, r_cs_d}    <= 3'b111;
      {r_mosi_s1, r_mosi_s2}        <= 2'b00;
    end else begin
      {r_clk_s1, r_clk_s2, r_clk_d} <= {i_spi_clk, r_clk_s1, r_clk_s2};
      {r_cs_s1, r_cs_s2, r_cs_d}    <= {i_spi_cs, r_cs_s1, r_cs_s2};
      {r_mosi_s1, r_mosi_s2}        <= {i_spi_mosi, r_mosi_s1};
    end
  end

  assign w_clk_rise = r_clk_s2 & ~r_clk_d;
  assign w_clk_fall = ~r_clk_s2 & r_clk_d;
  assign w_lead     = CPOL ? w_clk_fall : w_clk_rise;
  assign w_trail    = CPOL ? w_clk_rise : w_clk_fall;
  assign w_sample   = CPHA ? w_trail : w_lead;
  assign w_drive    = CPHA ? w_lead : w_trail;
  assign w_cs_fall  = ~r_cs_s2 & r_cs_d;
  assign w_cs_rise  = r_cs_s2 & ~r_cs_d;

  assign w_tx_push = i_tx_valid & ~w_tx_full;

  hps_spi_bridge_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_tx_fifo (
    .i_clk(i_sys_clk), .i_reset_n(i_reset_n),
    .i_push(w_tx_push), .i_data(i_tx_data), .o_full(w_tx_full),
    .i_pop(w_tx_pop), .o_data(w_tx_head), .o_empty(w_tx_empty)
  );

  hps_spi_bridge_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_rx_fifo (
    .i_clk(i_sys_clk), .i_reset_n(i_reset_n),
    .i_push(w_rx_push), .i_data(w_rx_sh_nxt), .o_full(w_rx_full),
    .i_pop(i_rx_ready), .o_data(o_rx_data), .o_empty(w_rx_empty)
  );

  always_ff @(posedge i_sys_clk) begin
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  // A drive edge at count 0 belongs to a word boundary whose MSB is already on
  // MISO (CPHA=1 leading edge, or CPHA=0 trailing edge after the last sample).
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_rx_sh_nxt = r_rx_sh;
    w_tx_sh_nxt = r_tx_sh;
    w_miso_nxt  = r_miso;
    w_load      = 1'b0;
    w_rx_push   = 1'b0;
    w_frame_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = ST_ACTIVE;
          w_count_nxt = '0;
          w_load      = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (w_sample) begin
          w_rx_sh_nxt = {r_rx_sh[WORD_W-2:0], r_mosi_s2};
          if (r_count == LAST_BIT) begin
            w_rx_push   = 1'b1;
            w_count_nxt = '0;
            w_load      = ~w_cs_rise;
          end else begin
            w_count_nxt = r_count + CNT_ONE;
          end
        end else if (w_drive && (r_count != '0)) begin
          w_tx_sh_nxt = {r_tx_sh[WORD_W-2:0], 1'b0};
          w_miso_nxt  = r_tx_sh[WORD_W-2];
        end
        if (w_cs_rise) begin
          w_state_nxt = ST_IDLE;
          w_miso_nxt  = 1'b0;
          w_frame_set = (w_count_nxt != '0);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_tx_pop       = w_load & ~w_tx_empty;
    w_underrun_set = w_load & w_tx_empty;
    if (w_load) begin
      w_tx_sh_nxt = w_tx_empty ? UNDERRUN_WORD : w_tx_head;
      w_miso_nxt  = w_tx_sh_nxt[WORD_W-1];
    end
  end

  // Full + pop + push keeps the word, so only an unpopped full FIFO drops it.
  assign w_overflow_set = w_rx_push & w_rx_full & ~i_rx_ready;

  always_ff @(posedge i_sys_clk) begin
    if (!i_reset_n) begin
      r_count  <= '0;
      r_rx_sh  <= '0;
      r_tx_sh  <= '0;
      r_miso   <= 1'b0;
      r_strobe <= 1'b0;
      r_status <= '0;
    end else begin
      r_count  <= w_count_nxt;
      r_rx_sh  <= w_rx_sh_nxt;
      r_tx_sh  <= w_tx_sh_nxt;
      r_miso   <= w_miso_nxt;
      r_strobe <= w_rx_push;
      r_status <= pack_status(
        i_io_enable, i_osd_enable, i_fpga_enable,
        w_frame_set    | (r_status[STAT_FRAME_ERR]   & ~i_clr_flags),
        w_underrun_set | (r_status[STAT_TX_UNDERRUN] & ~i_clr_flags),
        w_overflow_set | (r_status[STAT_RX_OVERFLOW] & ~i_clr_flags),
        w_state_nxt == ST_ACTIVE);
    end
  end

  assign o_spi_miso  = r_miso;
  assign o_io_strobe = r_strobe;
  assign o_tx_ready  = ~w_tx_full;
  assign o_rx_valid  = ~w_rx_empty;
  assign o_status    = r_status;

endmodule

// File: tb/tb_hps_spi_bridge.sv
// Testbench for hps_spi_bridge: an HPS-side SPI master model drives six bridge
// instances covering all CPOL/CPHA modes and 8/16/32-bit words.
module tb_hps_spi_bridge;

  localparam int NDUT = 6;
  localparam int HALF = 8;
  localparam int DEPTH = 8;
  localparam int CFG_W [NDUT] = '{16, 16, 16, 16, 8, 32};
  localparam bit CFG_CPOL [NDUT] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam bit CFG_CPHA [NDUT] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [31:0] UNDERRUN32 = 32'hC35A_9E17;

  logic sysClk = 1'b0;
  logic resetN;
  logic clrFlags, fpgaEn, osdEn, ioEn;
  logic [NDUT-1:0] spiClk, spiCs, spiMosi, txValid, rxReady;
  logic [NDUT-1:0][31:0] txData;
  wire  [NDUT-1:0] spiMiso, txReady, rxValid, ioStrobe;
  wire  [NDUT-1:0][31:0] rxData, status;

  int nChecks = 0;
  int nFails = 0;
  int strobeCnt [NDUT];
  logic [31:0] mosiBuf [16];
  logic [31:0] misoBuf [16];
  logic csSeen;

  always #5 sysClk = ~sysClk;

  for (genvar g = 0; g < NDUT; g++) begin : gDut
    localparam int W = CFG_W[g];
    wire [W-1:0] rxW;
    hps_spi_bridge #(
      .WORD_W(W), .DEPTH(DEPTH), .CPOL(CFG_CPOL[g]), .CPHA(CFG_CPHA[g]),
      .UNDERRUN_WORD(W'(UNDERRUN32))
    ) dut (
      .i_sys_clk(sysClk), .i_reset_n(resetN),
      .i_spi_clk(spiClk[g]), .i_spi_cs(spiCs[g]), .i_spi_mosi(spiMosi[g]),
      .o_spi_miso(spiMiso[g]),
      .i_tx_data(txData[g][W-1:0]), .i_tx_valid(txValid[g]), .o_tx_ready(txReady[g]),
      .o_rx_data(rxW), .o_rx_valid(rxValid[g]), .i_rx_ready(rxReady[g]),
      .o_io_strobe(ioStrobe[g]), .i_clr_flags(clrFlags),
      .i_fpga_enable(fpgaEn), .i_osd_enable(osdEn), .i_io_enable(ioEn),
      .o_status(status[g])
    );
    assign rxData[g] = 32'(rxW);
  end

  always @(negedge sysClk) begin
    for (int k = 0; k < NDUT; k++) if (ioStrobe[k] === 1'b1) strobeCnt[k]++;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] wmask(input int d);
    return (CFG_W[d] == 32) ? 32'hFFFF_FFFF : ((32'h1 << CFG_W[d]) - 32'h1);
  endfunction

  task automatic waitSys(input int n);
    repeat (n) @(negedge sysClk);
  endtask

  task automatic hps_begin(input int d);
    if (!CFG_CPHA[d]) spiMosi[d] = mosiBuf[0][CFG_W[d]-1];
    spiCs[d] = 1'b0;
    waitSys(2 * HALF);
    csSeen = status[d][0];
  endtask

  // One SPI bit; n is the bit number counted from the start of the frame.
  task automatic hps_bit(input int d, input int n);
    int w, b, w2, b2;
    w  = n / CFG_W[d];
    b  = CFG_W[d] - 1 - (n % CFG_W[d]);
    w2 = (n + 1) / CFG_W[d];
    b2 = CFG_W[d] - 1 - ((n + 1) % CFG_W[d]);
    if (CFG_CPHA[d]) begin
      spiClk[d] = ~CFG_CPOL[d];
      spiMosi[d] = mosiBuf[w][b];
      waitSys(HALF);
      misoBuf[w][b] = spiMiso[d];
      spiClk[d] = CFG_CPOL[d];
      waitSys(HALF);
    end else begin
      waitSys(HALF);
      misoBuf[w][b] = spiMiso[d];
      spiClk[d] = ~CFG_CPOL[d];
      waitSys(HALF);
      spiClk[d] = CFG_CPOL[d];
      spiMosi[d] = mosiBuf[w2][b2];
    end
  endtask

  task automatic hps_end(input int d);
    waitSys(HALF);
    spiCs[d] = 1'b1;
    waitSys(2 * HALF);
  endtask

  task automatic hps_frame(input int d, input int nBits);
    hps_begin(d);
    for (int n = 0; n < nBits; n++) hps_bit(d, n);
    hps_end(d);
  endtask

  task automatic pushTx(input int d, input logic [31:0] data);
    nChecks++;
    if (txReady[d] !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL tx_ready d%0d: got %b, expected 1", d, txReady[d]);
    end
    txData[d] = data;
    txValid[d] = 1'b1;
    waitSys(1);
    txValid[d] = 1'b0;
  endtask

  task automatic popRx(input int d, output logic [31:0] data, output logic valid);
    valid = rxValid[d];
    data = rxData[d];
    rxReady[d] = 1'b1;
    waitSys(1);
    rxReady[d] = 1'b0;
  endtask

  task automatic pulseClear();
    clrFlags = 1'b1;
    waitSys(1);
    clrFlags = 1'b0;
    waitSys(2);
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    waitSys(4);
    resetN = 1'b1;
    waitSys(3);
    nChecks++;
    if (spiMiso[0] !== 1'b0) begin nFails++; $display("[TB] FAIL reset_miso: got %b, expected 0", spiMiso[0]); end
    nChecks++;
    if (ioStrobe[0] !== 1'b0) begin nFails++; $display("[TB] FAIL reset_strobe: got %b, expected 0", ioStrobe[0]); end
    nChecks++;
    if (rxValid[0] !== 1'b0) begin nFails++; $display("[TB] FAIL reset_rx_valid: got %b, expected 0", rxValid[0]); end
    nChecks++;
    if (txReady[0] !== 1'b1) begin nFails++; $display("[TB] FAIL reset_tx_ready: got %b, expected 1", txReady[0]); end
    nChecks++;
    if (status[0] !== 32'h0014_0000) begin nFails++; $display("[TB] FAIL reset_status: got %h, expected 00140000", status[0]); end
  endtask

  task automatic test_basic();
    logic [31:0] got;
    logic v;
    int s;
    mosiBuf[0] = 32'h1234;
    pushTx(0, 32'hA55A);
    s = strobeCnt[0];
    hps_frame(0, 16);
    nChecks++;
    if (csSeen !== 1'b1) begin nFails++; $display("[TB] FAIL basic_cs_active: got %b, expected 1", csSeen); end
    nChecks++;
    if (strobeCnt[0] - s != 1) begin nFails++; $display("[TB] FAIL basic_strobes: got %0d, expected 1", strobeCnt[0] - s); end
    nChecks++;
    if (misoBuf[0][15:0] !== 16'hA55A) begin nFails++; $display("[TB] FAIL basic_miso: got %h, expected a55a", misoBuf[0][15:0]); end
    popRx(0, got, v);
    nChecks++;
    if (v !== 1'b1 || got !== 32'h1234) begin nFails++; $display("[TB] FAIL basic_rx: got %h valid %b, expected 00001234 valid 1", got, v); end
    nChecks++;
    if (rxValid[0] !== 1'b0) begin nFails++; $display("[TB] FAIL basic_rx_empty: got %b, expected 0", rxValid[0]); end
    // The reload after the only word finds TX empty, so tx_underrun is set.
    nChecks++;
    if (status[0] !== 32'h0014_0004) begin nFails++; $display("[TB] FAIL basic_status: got %h, expected 00140004", status[0]); end
  endtask

  task automatic test_underrun();
    logic [31:0] got;
    logic v;
    int s;
    pulseClear();
    nChecks++;
    if (status[0][2] !== 1'b0) begin nFails++; $display("[TB] FAIL underrun_pre_clear: got %b, expected 0", status[0][2]); end
    for (int k = 0; k < 3; k++) mosiBuf[k] = $urandom & 32'hFFFF;
    s = strobeCnt[0];
    hps_frame(0, 48);
    for (int k = 0; k < 3; k++) begin
      nChecks++;
      if (misoBuf[k][15:0] !== UNDERRUN32[15:0]) begin nFails++; $display("[TB] FAIL underrun_miso%0d: got %h, expected %h", k, misoBuf[k][15:0], UNDERRUN32[15:0]); end
      popRx(0, got, v);
      nChecks++;
      if (v !== 1'b1 || got !== mosiBuf[k]) begin nFails++; $display("[TB] FAIL underrun_rx%0d: got %h valid %b, expected %h", k, got, v, mosiBuf[k]); end
    end
    nChecks++;
    if (strobeCnt[0] - s != 3) begin nFails++; $display("[TB] FAIL underrun_strobes: got %0d, expected 3", strobeCnt[0] - s); end
    nChecks++;
    if (status[0][2] !== 1'b1) begin nFails++; $display("[TB] FAIL underrun_flag: got %b, expected 1", status[0][2]); end
    pulseClear();
    nChecks++;
    if (status[0][2] !== 1'b0) begin nFails++; $display("[TB] FAIL underrun_clear: got %b, expected 0", status[0][2]); end
  endtask

  task automatic test_overflow();
    logic [31:0] got;
    logic v;
    int s;
    for (int k = 0; k < 9; k++) mosiBuf[k] = $urandom & 32'hFFFF;
    s = strobeCnt[0];
    hps_frame(0, 9 * 16);
    nChecks++;
    if (strobeCnt[0] - s != 9) begin nFails++; $display("[TB] FAIL overflow_strobes: got %0d, expected 9", strobeCnt[0] - s); end
    nChecks++;
    if (status[0][1] !== 1'b1) begin nFails++; $display("[TB] FAIL overflow_flag: got %b, expected 1", status[0][1]); end
    nChecks++;
    if (status[0][3] !== 1'b0) begin nFails++; $display("[TB] FAIL overflow_frame_err: got %b, expected 0", status[0][3]); end
    for (int k = 0; k < DEPTH; k++) begin
      popRx(0, got, v);
      nChecks++;
      if (v !== 1'b1 || got !== mosiBuf[k]) begin nFails++; $display("[TB] FAIL overflow_rx%0d: got %h valid %b, expected %h", k, got, v, mosiBuf[k]); end
    end
    nChecks++;
    if (rxValid[0] !== 1'b0) begin nFails++; $display("[TB] FAIL overflow_drained: got %b, expected 0", rxValid[0]); end
    pulseClear();
  endtask

  task automatic test_frame_err();
    logic [31:0] got;
    logic v;
    int s;
    mosiBuf[0] = $urandom & 32'hFFFF;
    s = strobeCnt[0];
    hps_begin(0);
    for (int n = 0; n < 7; n++) hps_bit(0, n);
    hps_end(0);
    nChecks++;
    if (strobeCnt[0] != s) begin nFails++; $display("[TB] FAIL partial_strobes: got %0d, expected 0", strobeCnt[0] - s); end
    nChecks++;
    if (rxValid[0] !== 1'b0) begin nFails++; $display("[TB] FAIL partial_rx_valid: got %b, expected 0", rxValid[0]); end
    nChecks++;
    if (status[0][3] !== 1'b1) begin nFails++; $display("[TB] FAIL partial_frame_err: got %b, expected 1", status[0][3]); end
    pulseClear();
    mosiBuf[0] = 32'hBEEF;
    hps_frame(0, 16);
    popRx(0, got, v);
    nChecks++;
    if (v !== 1'b1 || got !== 32'hBEEF) begin nFails++; $display("[TB] FAIL after_partial_rx: got %h valid %b, expected 0000beef", got, v); end
    nChecks++;
    if (strobeCnt[0] - s != 1) begin nFails++; $display("[TB] FAIL after_partial_strobes: got %0d, expected 1", strobeCnt[0] - s); end
    nChecks++;
    if (status[0][3] !== 1'b0) begin nFails++; $display("[TB] FAIL after_partial_frame_err: got %b, expected 0", status[0][3]); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got;
    logic v;
    int s;
    mosiBuf[0] = $urandom & 32'hFFFF;
    hps_begin(0);
    for (int n = 0; n < 5; n++) hps_bit(0, n);
    resetN = 1'b0;
    waitSys(2);
    spiCs[0] = 1'b1;
    spiClk[0] = CFG_CPOL[0];
    waitSys(4);
    resetN = 1'b1;
    waitSys(3);
    nChecks++;
    if (spiMiso[0] !== 1'b0 || ioStrobe[0] !== 1'b0 || rxValid[0] !== 1'b0 || txReady[0] !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL midreset_outputs: got miso %b strobe %b rx_valid %b tx_ready %b, expected 0 0 0 1",
               spiMiso[0], ioStrobe[0], rxValid[0], txReady[0]);
    end
    nChecks++;
    if (status[0] !== 32'h0014_0000) begin nFails++; $display("[TB] FAIL midreset_status: got %h, expected 00140000", status[0]); end
    mosiBuf[0] = 32'h0F0F;
    s = strobeCnt[0];
    hps_frame(0, 16);
    nChecks++;
    if (strobeCnt[0] - s != 1) begin nFails++; $display("[TB] FAIL midreset_strobes: got %0d, expected 1", strobeCnt[0] - s); end
    popRx(0, got, v);
    nChecks++;
    if (v !== 1'b1 || got !== 32'h0F0F) begin nFails++; $display("[TB] FAIL midreset_rx: got %h valid %b, expected 00000f0f", got, v); end
    nChecks++;
    if (rxValid[0] !== 1'b0) begin nFails++; $display("[TB] FAIL midreset_once: got %b, expected 0", rxValid[0]); end
  endtask

  // Back-to-back words per frame on every mode/width; the TX queue model
  // predicts MISO words, falling back to the underrun word once it runs dry.
  task automatic test_loopback();
    logic [31:0] txQ [$];
    logic [31:0] exp, got;
    logic v;
    int nW, nTx, s;
    for (int d = 0; d < NDUT; d++) begin
      for (int rep = 0; rep < 2; rep++) begin
        nW = $urandom_range(2, 4);
        nTx = $urandom_range(0, nW);
        txQ.delete();
        for (int k = 0; k < nTx; k++) begin
          exp = $urandom & wmask(d);
          txQ.push_back(exp);
          pushTx(d, exp);
        end
        for (int k = 0; k < nW; k++) mosiBuf[k] = $urandom & wmask(d);
        s = strobeCnt[d];
        hps_frame(d, nW * CFG_W[d]);
        for (int k = 0; k < nW; k++) begin
          if (txQ.size() > 0) exp = txQ.pop_front();
          else exp = UNDERRUN32 & wmask(d);
          got = misoBuf[k] & wmask(d);
          nChecks++;
          if (got !== exp) begin nFails++; $display("[TB] FAIL loop_miso d%0d w%0d: got %h, expected %h", d, k, got, exp); end
        end
        nChecks++;
        if (strobeCnt[d] - s != nW) begin nFails++; $display("[TB] FAIL loop_strobes d%0d: got %0d, expected %0d", d, strobeCnt[d] - s, nW); end
        for (int k = 0; k < nW; k++) begin
          popRx(d, got, v);
          nChecks++;
          if (v !== 1'b1 || got !== mosiBuf[k]) begin nFails++; $display("[TB] FAIL loop_rx d%0d w%0d: got %h valid %b, expected %h", d, k, got, v, mosiBuf[k]); end
        end
        nChecks++;
        if (rxValid[d] !== 1'b0) begin nFails++; $display("[TB] FAIL loop_rx_empty d%0d: got %b, expected 0", d, rxValid[d]); end
      end
    end
  endtask

  initial begin
    resetN = 1'b0;
    clrFlags = 1'b0;
    fpgaEn = 1'b1;
    osdEn = 1'b0;
    ioEn = 1'b1;
    txValid = '0;
    rxReady = '0;
    txData = '0;
    spiCs = '1;
    spiMosi = '0;
    for (int d = 0; d < NDUT; d++) spiClk[d] = CFG_CPOL[d];
    test_reset();
    test_basic();
    test_underrun();
    test_overflow();
    test_frame_err();
    test_reset_mid();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
